// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: serial programming and optional readback master for a pair
// of LUT4 cells behind a one-hot bit-select / RnW / data_in port.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cfg_valid/cfg_ready           request handshake (ready = idle)
//   cfg_data[15:0]                truth table, bit k -> LUT address k
//   cfg_sel                       0 = LUT_0 (_1 port), 1 = LUT_1 (_2 port)
//   cfg_verify                    read back and compare after programming
//   write_in_1/2[0:15]            one-hot bit select per LUT
//   RnW_1/2                       1 = read, 0 = write
//   data_in_1/2                   write data bit
//   out_lut_1/2                   LUT read data
//   done                          one-cycle completion pulse
//   err, err_idx[3:0]             sticky verify mismatch and first failing bit
module lut_cfg_loader #(
  parameter int unsigned N_BITS = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [N_BITS-1:0] cfg_data,
  input  logic              cfg_sel,
  input  logic              cfg_verify,
  output logic [0:N_BITS-1] write_in_1,
  output logic [0:N_BITS-1] write_in_2,
  output logic              RnW_1,
  output logic              RnW_2,
  output logic              data_in_1,
  output logic              data_in_2,
  input  logic              out_lut_1,
  input  logic              out_lut_2,
  output logic              done,
  output logic              err,
  output logic [3:0]        err_idx
);

  localparam int unsigned IDX_W = $clog2(N_BITS);
  localparam int unsigned LAT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [N_BITS-1:0]   data_q, data_d;
  logic                sel_q, sel_d;
  logic                verify_q, verify_d;
  logic                err_q, err_d;
  logic [3:0]          err_idx_q, err_idx_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                done_q, done_d;
  logic [0:N_BITS-1]   write_in_1_q, write_in_1_d;
  logic [0:N_BITS-1]   write_in_2_q, write_in_2_d;
  logic                rnw_1_q, rnw_1_d;
  logic                rnw_2_q, rnw_2_d;
  logic                data_in_1_q, data_in_1_d;
  logic                data_in_2_q, data_in_2_d;

  logic                rd_bit;
  logic [0:N_BITS-1]   sel_vec;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      lat_q        <= '0;
      data_q       <= '0;
      sel_q        <= 1'b0;
      verify_q     <= 1'b0;
      err_q        <= 1'b0;
      err_idx_q    <= '0;
      cfg_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      write_in_1_q <= '0;
      write_in_2_q <= '0;
      rnw_1_q      <= 1'b1;
      rnw_2_q      <= 1'b1;
      data_in_1_q  <= 1'b0;
      data_in_2_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      verify_q     <= verify_d;
      err_q        <= err_d;
      err_idx_q    <= err_idx_d;
      cfg_ready_q  <= cfg_ready_d;
      done_q       <= done_d;
      write_in_1_q <= write_in_1_d;
      write_in_2_q <= write_in_2_d;
      rnw_1_q      <= rnw_1_d;
      rnw_2_q      <= rnw_2_d;
      data_in_1_q  <= data_in_1_d;
      data_in_2_q  <= data_in_2_d;
    end
  end

  // Next-state logic; port outputs are derived from the next state so the
  // registered port always reflects the state/idx of the current cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    data_d       = data_q;
    sel_d        = sel_q;
    verify_d     = verify_q;
    err_d        = err_q;
    err_idx_d    = err_idx_q;
    write_in_1_d = '0;
    write_in_2_d = '0;
    rnw_1_d      = 1'b1;
    rnw_2_d      = 1'b1;
    data_in_1_d  = 1'b0;
    data_in_2_d  = 1'b0;
    sel_vec      = '0;
    rd_bit       = sel_q ? out_lut_2 : out_lut_1;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          data_d    = cfg_data;
          sel_d     = cfg_sel;
          verify_d  = cfg_verify;
          err_d     = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          lat_d     = '0;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        // idx wraps to 0 exactly as the phase ends
        idx_d = idx_q + IDX_W'(1);
        lat_d = '0;
        if (idx_q == IDX_W'(N_BITS - 1)) begin
          state_d = verify_q ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          lat_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if ((rd_bit != data_q[idx_q]) && !err_q) begin
            err_d     = 1'b1;
            err_idx_d = 4'(idx_q);
          end
          if (idx_q == IDX_W'(N_BITS - 1)) begin
            state_d = S_DONE;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cfg_ready_d = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);

    // Only the targeted port leaves idle, and only in WRITE/READ
    sel_vec[idx_d] = 1'b1;
    if ((state_d == S_WRITE) || (state_d == S_READ)) begin
      if (!sel_d) begin
        write_in_1_d = sel_vec;
        rnw_1_d      = (state_d == S_READ);
        data_in_1_d  = (state_d == S_WRITE) ? data_d[idx_d] : 1'b0;
      end else begin
        write_in_2_d = sel_vec;
        rnw_2_d      = (state_d == S_READ);
        data_in_2_d  = (state_d == S_WRITE) ? data_d[idx_d] : 1'b0;
      end
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_idx    = err_idx_q;
  assign write_in_1 = write_in_1_q;
  assign write_in_2 = write_in_2_q;
  assign RnW_1      = rnw_1_q;
  assign RnW_2      = rnw_2_q;
  assign data_in_1  = data_in_1_q;
  assign data_in_2  = data_in_2_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed self-checking bench for lut_cfg_loader with behavioural LUT models.
// Instance a: RD_LAT=1; instances b and c: RD_LAT=0 and RD_LAT=3.
module tb_lut_cfg_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // LUT ports: index 0/1 = dut a port 1/2, 2/3 = dut b, 4/5 = dut c
  logic [0:15] wi [6];
  logic        rnw [6];
  logic        din [6];
  logic [5:0]  dout;
  logic [15:0] mem [6];
  logic [15:0] stuck [6];

  logic        valid_a, sel_a, verify_a;
  logic [15:0] data_a;
  logic        ready_a, done_a, err_a;
  logic [3:0]  err_idx_a;

  logic        valid_x, sel_x, verify_x;
  logic [15:0] data_x;
  logic        ready_b, done_b, err_b;
  logic [3:0]  err_idx_b;
  logic        ready_c, done_c, err_c;
  logic [3:0]  err_idx_c;

  logic [15:0] vals [3];

  lut_cfg_loader #(.N_BITS(16), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_valid(valid_a), .cfg_ready(ready_a),
    .cfg_data(data_a), .cfg_sel(sel_a), .cfg_verify(verify_a),
    .write_in_1(wi[0]), .write_in_2(wi[1]), .RnW_1(rnw[0]), .RnW_2(rnw[1]),
    .data_in_1(din[0]), .data_in_2(din[1]), .out_lut_1(dout[0]), .out_lut_2(dout[1]),
    .done(done_a), .err(err_a), .err_idx(err_idx_a)
  );

  lut_cfg_loader #(.N_BITS(16), .RD_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_valid(valid_x), .cfg_ready(ready_b),
    .cfg_data(data_x), .cfg_sel(sel_x), .cfg_verify(verify_x),
    .write_in_1(wi[2]), .write_in_2(wi[3]), .RnW_1(rnw[2]), .RnW_2(rnw[3]),
    .data_in_1(din[2]), .data_in_2(din[3]), .out_lut_1(dout[2]), .out_lut_2(dout[3]),
    .done(done_b), .err(err_b), .err_idx(err_idx_b)
  );

  lut_cfg_loader #(.N_BITS(16), .RD_LAT(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .cfg_valid(valid_x), .cfg_ready(ready_c),
    .cfg_data(data_x), .cfg_sel(sel_x), .cfg_verify(verify_x),
    .write_in_1(wi[4]), .write_in_2(wi[5]), .RnW_1(rnw[4]), .RnW_2(rnw[5]),
    .data_in_1(din[4]), .data_in_2(din[5]), .out_lut_1(dout[4]), .out_lut_2(dout[5]),
    .done(done_c), .err(err_c), .err_idx(err_idx_c)
  );

  // LUT write model
  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (!rnw[i]) begin
        for (int k = 0; k < 16; k++) begin
          if (wi[i][k]) mem[i][k] <= din[i];
        end
      end
    end
  end

  // LUT read model with optional stuck-at-0 bits
  always_comb begin
    dout = '0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 16; k++) begin
        if (rnw[i] && wi[i][k] && mem[i][k] && !stuck[i][k]) dout[i] = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, " wi1"}, 32'(wi[0]), 32'h0);
    chk({tag, " rnw1"}, 32'(rnw[0]), 32'h1);
    chk({tag, " din1"}, 32'(din[0]), 32'h0);
    chk({tag, " wi2"}, 32'(wi[1]), 32'h0);
    chk({tag, " rnw2"}, 32'(rnw[1]), 32'h1);
    chk({tag, " din2"}, 32'(din[1]), 32'h0);
  endtask

  initial begin
    logic [15:0] d;
    for (int i = 0; i < 6; i++) stuck[i] = '0;
    vals[0] = 16'h1357;
    vals[1] = 16'hECA8;
    vals[2] = 16'h0F0F;
    rst_n = 1'b0;
    valid_a = 1'b0; sel_a = 1'b0; verify_a = 1'b0; data_a = '0;
    valid_x = 1'b0; sel_x = 1'b0; verify_x = 1'b0; data_x = '0;
    tick(); tick();
    // Reset state
    chk("rst ready", 32'(ready_a), 32'h1);
    chk("rst done", 32'(done_a), 32'h0);
    chk("rst err", 32'(err_a), 32'h0);
    chk("rst err_idx", 32'(err_idx_a), 32'h0);
    chk_idle_a("rst");
    rst_n = 1'b1;
    tick();

    // 1: A5C3 to LUT_0, no verify
    d = 16'hA5C3;
    valid_a = 1'b1; data_a = d; sel_a = 1'b0; verify_a = 1'b0;
    tick();
    valid_a = 1'b0; data_a = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t1 wi1 k%0d", k), 32'(wi[0]), 32'(16'h8000 >> k));
      chk($sformatf("t1 rnw1 k%0d", k), 32'(rnw[0]), 32'h0);
      chk($sformatf("t1 din1 k%0d", k), 32'(din[0]), 32'(d[k]));
      chk($sformatf("t1 wi2 k%0d", k), 32'(wi[1]), 32'h0);
      chk($sformatf("t1 rnw2 k%0d", k), 32'(rnw[1]), 32'h1);
      chk($sformatf("t1 ready k%0d", k), 32'(ready_a), 32'h0);
      tick();
    end
    chk("t1 done", 32'(done_a), 32'h1);
    chk("t1 ready@done", 32'(ready_a), 32'h0);
    chk_idle_a("t1 done");
    chk("t1 lut0", 32'(mem[0]), 32'hA5C3);
    tick();
    chk("t1 done end", 32'(done_a), 32'h0);
    chk("t1 ready end", 32'(ready_a), 32'h1);

    // 2: 6996 to LUT_1, verify, RD_LAT=1
    d = 16'h6996;
    valid_a = 1'b1; data_a = d; sel_a = 1'b1; verify_a = 1'b1;
    tick();
    valid_a = 1'b0; data_a = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t2 wi2 k%0d", k), 32'(wi[1]), 32'(16'h8000 >> k));
      chk($sformatf("t2 din2 k%0d", k), 32'(din[1]), 32'(d[k]));
      chk($sformatf("t2 rnw2 k%0d", k), 32'(rnw[1]), 32'h0);
      chk($sformatf("t2 wi1 k%0d", k), 32'(wi[0]), 32'h0);
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 2; l++) begin
        chk($sformatf("t2 rd wi2 k%0d l%0d", k, l), 32'(wi[1]), 32'(16'h8000 >> k));
        chk($sformatf("t2 rd rnw2 k%0d l%0d", k, l), 32'(rnw[1]), 32'h1);
        chk($sformatf("t2 rd done k%0d l%0d", k, l), 32'(done_a), 32'h0);
        tick();
      end
    end
    chk("t2 done", 32'(done_a), 32'h1);
    chk("t2 err", 32'(err_a), 32'h0);
    chk("t2 err_idx", 32'(err_idx_a), 32'h0);
    chk("t2 lut1", 32'(mem[1]), 32'h6996);
    chk_idle_a("t2 done");
    tick();

    // 3: FFFF with LUT_1 bits 5 and 9 stuck at 0
    stuck[1] = 16'h0220;
    valid_a = 1'b1; data_a = 16'hFFFF; sel_a = 1'b1; verify_a = 1'b1;
    tick();
    valid_a = 1'b0;
    repeat (48) tick();
    chk("t3 done", 32'(done_a), 32'h1);
    chk("t3 err", 32'(err_a), 32'h1);
    chk("t3 err_idx", 32'(err_idx_a), 32'h5);
    tick();
    chk("t3 err hold", 32'(err_a), 32'h1);
    chk("t3 err_idx hold", 32'(err_idx_a), 32'h5);
    stuck[1] = '0;
    valid_a = 1'b1; data_a = 16'h0000; sel_a = 1'b0; verify_a = 1'b0;
    tick();
    valid_a = 1'b0;
    chk("t3b err cleared", 32'(err_a), 32'h0);
    chk("t3b err_idx cleared", 32'(err_idx_a), 32'h0);
    repeat (16) tick();
    chk("t3b done", 32'(done_a), 32'h1);
    chk("t3b err", 32'(err_a), 32'h0);
    chk("t3b lut0", 32'(mem[0]), 32'h0000);
    tick();

    // 4: cfg_valid held high, data changes every cycle
    valid_a = 1'b1; sel_a = 1'b0; verify_a = 1'b0;
    for (int c = 0; c < 54; c++) begin
      chk($sformatf("t4 ready c%0d", c), 32'(ready_a), 32'((c % 18) == 0));
      chk($sformatf("t4 done c%0d", c), 32'(done_a), 32'((c % 18) == 17));
      if ((c % 18) == 17) chk($sformatf("t4 lut0 c%0d", c), 32'(mem[0]), 32'(vals[c / 18]));
      data_a = ((c % 18) == 0) ? vals[c / 18] : 16'($urandom);
      tick();
    end
    valid_a = 1'b0;
    tick();

    // 5: reset during WRITE at idx 7
    valid_a = 1'b1; data_a = 16'hBEEF; sel_a = 1'b0; verify_a = 1'b0;
    tick();
    valid_a = 1'b0;
    repeat (7) tick();
    chk("t5 idx7", 32'(wi[0]), 32'(16'h8000 >> 7));
    #2 rst_n = 1'b0;
    #1;
    chk("t5 ready", 32'(ready_a), 32'h1);
    chk("t5 done", 32'(done_a), 32'h0);
    chk_idle_a("t5 async");
    tick();
    rst_n = 1'b1;
    tick();
    valid_a = 1'b1; data_a = 16'h5AA5; sel_a = 1'b0; verify_a = 1'b0;
    tick();
    valid_a = 1'b0;
    repeat (16) tick();
    chk("t5 done after", 32'(done_a), 32'h1);
    chk("t5 lut0", 32'(mem[0]), 32'h5AA5);
    tick();

    // 6: RD_LAT=0 (dut b) and RD_LAT=3 (dut c), data 0001 verify
    chk("t6 ready b", 32'(ready_b), 32'h1);
    chk("t6 ready c", 32'(ready_c), 32'h1);
    valid_x = 1'b1; data_x = 16'h0001; sel_x = 1'b0; verify_x = 1'b1;
    tick();
    valid_x = 1'b0;
    for (int n = 1; n <= 81; n++) begin
      chk($sformatf("t6 done_b n%0d", n), 32'(done_b), 32'(n == 33));
      chk($sformatf("t6 done_c n%0d", n), 32'(done_c), 32'(n == 81));
      if (n == 33) chk("t6 err_b", 32'(err_b), 32'h0);
      if (n == 81) chk("t6 err_c", 32'(err_c), 32'h0);
      tick();
    end
    chk("t6 lut b", 32'(mem[2]), 32'h0001);
    chk("t6 lut c", 32'(mem[4]), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
